// File: rtl/mdu_pkg.sv
// Shared MDU opcodes, latency defaults and the calc result record.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MADDU = 4'd1;
    localparam logic [3:0] MDU_MULT  = 4'd2;
    localparam logic [3:0] MDU_MULTU = 4'd3;
    localparam logic [3:0] MDU_DIV   = 4'd4;
    localparam logic [3:0] MDU_DIVU  = 4'd5;
    localparam logic [3:0] MDU_MTHI  = 4'd6;
    localparam logic [3:0] MDU_MTLO  = 4'd7;
    localparam logic [3:0] MDU_MFHI  = 4'd8;
    localparam logic [3:0] MDU_MFLO  = 4'd9;
    localparam logic [3:0] MDU_MADD  = 4'd10;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    // is_md: op starts a multi-cycle operation; commit: result is written at the end
    typedef struct packed {
        logic        is_md;
        logic        is_div;
        logic        commit;
        logic [63:0] res;
    } calc_res_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic for the MDU: products, accumulates, quotients.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output calc_res_t   res
);

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, q_mag, r_mag, sq, sr, uq, ur;

    // Signed division goes through magnitudes so 0x80000000 / -1 cannot overflow
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        abs_a  = a[31] ? (~a + 32'd1) : a;
        abs_b  = b[31] ? (~b + 32'd1) : b;
        q_mag  = abs_a / abs_b;
        r_mag  = abs_a % abs_b;
        sq     = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        sr     = a[31] ? (~r_mag + 32'd1) : r_mag;
        uq     = a / b;
        ur     = a % b;

        res = '0;
        case (op)
            MDU_MULT:  begin res.is_md = 1'b1; res.commit = 1'b1; res.res = prod_s; end
            MDU_MULTU: begin res.is_md = 1'b1; res.commit = 1'b1; res.res = prod_u; end
            MDU_MADD:  begin res.is_md = 1'b1; res.commit = 1'b1; res.res = {hi, lo} + prod_s; end
            MDU_MADDU: begin res.is_md = 1'b1; res.commit = 1'b1; res.res = {hi, lo} + prod_u; end
            MDU_DIV: begin
                res.is_md  = 1'b1;
                res.is_div = 1'b1;
                res.commit = (b != 32'd0);
                res.res    = {sr, sq};
            end
            MDU_DIVU: begin
                res.is_md  = 1'b1;
                res.is_div = 1'b1;
                res.commit = (b != 32'd0);
                res.res    = {ur, uq};
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO registers, busy counter modelling latency.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] Out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        commit_q, commit_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    calc_res_t   calc;

    mdu_calc u_calc (
        .op  (MDUOp),
        .a   (A),
        .b   (B),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (calc)
    );

    // Counter is the state: zero is IDLE, nonzero is RUN
    always_comb begin
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && commit_q) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end else if (Start && calc.is_md) begin
            pend_d   = calc.res;
            commit_d = calc.commit;
            cnt_d    = calc.is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (MDUOp == MDU_MTHI) begin
            hi_d = A;
        end else if (MDUOp == MDU_MTLO) begin
            lo_d = A;
        end
    end

    // State registers; reset abandons any pending result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= 4'd0;
            pend_q   <= 64'd0;
            commit_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // mfhi/mflo read path into the E-stage result mux
    always_comb begin
        Out = 32'd0;
        if (MDUOp == MDU_MFHI) Out = hi_q;
        else if (MDUOp == MDU_MFLO) Out = lo_q;
    end

    assign Busy = (cnt_q != 4'd0);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomized and directed bench for mdu against a transaction-level model.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  MDUOp = MDU_NONE;
    logic [31:0] A = '0, B = '0;
    logic        Busy;
    logic [31:0] Out, HI, LO;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
        .A(A), .B(B), .Busy(Busy), .Out(Out), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic from the architectural rules, using 64-bit integers
    function automatic void ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo,
                                   output logic commit, output logic [63:0] r);
        longint sa, sb, q, rm;
        logic [63:0] acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        acc = {hi, lo};
        commit = 1'b1;
        r = acc;
        case (op)
            MDU_MULT:  r = 64'(sa * sb);
            MDU_MULTU: r = {32'd0, a} * {32'd0, b};
            MDU_MADD:  r = acc + 64'(sa * sb);
            MDU_MADDU: r = acc + {32'd0, a} * {32'd0, b};
            MDU_DIV: begin
                if (b == 0) commit = 1'b0;
                else begin
                    q = sa / sb;
                    rm = sa % sb;
                    r = {rm[31:0], q[31:0]};
                end
            end
            MDU_DIVU: begin
                if (b == 0) commit = 1'b0;
                else r = {32'(a % b), 32'(a / b)};
            end
            default: commit = 1'b0;
        endcase
    endfunction

    task automatic chk_regs(input string tag);
        chk({tag, "_hi"}, 64'(HI), 64'(m_hi));
        chk({tag, "_lo"}, 64'(LO), 64'(m_lo));
        MDUOp = MDU_MFHI; #1;
        chk({tag, "_mfhi"}, 64'(Out), 64'(m_hi));
        MDUOp = MDU_MFLO; #1;
        chk({tag, "_mflo"}, 64'(Out), 64'(m_lo));
        MDUOp = MDU_NONE; #1;
        chk({tag, "_out0"}, 64'(Out), 64'd0);
    endtask

    // inj: 0 none, 1 second mult pulse while busy, 2 mtlo while busy
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
        logic c;
        logic [63:0] r;
        int n_exp, cnt;
        ref_md(op, a, b, m_hi, m_lo, c, r);
        n_exp = (op == MDU_DIV || op == MDU_DIVU) ? 10 : 5;
        Start = 1'b1; MDUOp = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0; MDUOp = MDU_NONE;
        chk("busy_start", 64'(Busy), 64'd1);
        cnt = 0;
        while (Busy === 1'b1 && cnt < 40) begin
            chk("hold_hi", 64'(HI), 64'(m_hi));
            chk("hold_lo", 64'(LO), 64'(m_lo));
            if (cnt == 1 && inj == 1) begin
                Start = 1'b1; MDUOp = MDU_MULT; A = $urandom; B = $urandom;
            end
            if (cnt == 1 && inj == 2) begin
                MDUOp = MDU_MTLO; A = 32'h1234_5678;
            end
            @(posedge clk); #1;
            Start = 1'b0; MDUOp = MDU_NONE;
            cnt++;
        end
        chk("busy_len", 64'(cnt), 64'(n_exp));
        if (c) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        chk_regs("md");
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        MDUOp = op; A = v;
        @(posedge clk); #1;
        MDUOp = MDU_NONE;
        if (op == MDU_MTHI) m_hi = v; else m_lo = v;
        chk("mt_hi", 64'(HI), 64'(m_hi));
        chk("mt_lo", 64'(LO), 64'(m_lo));
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] ops [8];
        logic [3:0] op;
        ops = '{MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};

        #2;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // mult / multu latency and results
        run_md(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_hi_lit", 64'(HI), 64'hFFFF_FFFF);
        chk("mult_lo_lit", 64'(LO), 64'hFFFF_FFFA);
        run_md(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 0);
        chk("multu_hi_lit", 64'(HI), 64'h2);

        // divide cases
        run_md(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_lo_lit", 64'(LO), 64'hFFFF_FFFD);
        chk("div_hi_lit", 64'(HI), 64'hFFFF_FFFF);
        run_md(MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 0);
        chk("divu_lo_lit", 64'(LO), 64'h7FFF_FFFC);
        run_md(MDU_DIV, 32'h1111, 32'd0, 0);
        run_md(MDU_DIVU, 32'h2222, 32'd0, 0);
        run_md(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_lo", 64'(LO), 64'h8000_0000);
        chk("div_ovf_hi", 64'(HI), 64'h0);

        // accumulate
        mt(MDU_MTHI, 32'd0);
        mt(MDU_MTLO, 32'hFFFF_FFFF);
        run_md(MDU_MADDU, 32'd1, 32'd1, 0);
        chk("maddu_hi_lit", 64'(HI), 64'd1);
        chk("maddu_lo_lit", 64'(LO), 64'd0);
        run_md(MDU_MADD, 32'hFFFF_FFFF, 32'd1, 0);

        // ignored inputs
        run_md(MDU_MULT, 32'd7, 32'd9, 1);
        run_md(MDU_DIVU, 32'd100, 32'd7, 2);
        Start = 1'b1; MDUOp = MDU_MFHI; A = 32'd5; B = 32'd5;
        @(posedge clk); #1;
        Start = 1'b0; MDUOp = MDU_NONE;
        chk("nonmd_start_busy", 64'(Busy), 64'd0);
        chk_regs("nonmd");

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == MDU_MTHI || op == MDU_MTLO) mt(op, rnd32());
            else run_md(op, rnd32(), rnd32(), 0);
        end

        // reset mid-run
        mt(MDU_MTHI, 32'hAAAA_5555);
        mt(MDU_MTLO, 32'h1357_9BDF);
        Start = 1'b1; MDUOp = MDU_DIV; A = 32'd1000; B = 32'd3;
        @(posedge clk); #1;
        Start = 1'b0; MDUOp = MDU_NONE;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        MDUOp = MDU_MFHI;
        #1;
        chk("midrst_busy", 64'(Busy), 64'd0);
        chk("midrst_hi", 64'(HI), 64'd0);
        chk("midrst_lo", 64'(LO), 64'd0);
        chk("midrst_out", 64'(Out), 64'd0);
        MDUOp = MDU_NONE;
        @(posedge clk); #1;
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (15) @(posedge clk);
        #1;
        chk("postrst_busy", 64'(Busy), 64'd0);
        chk_regs("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
